// File: rtl/shift_add_multiplier_if.sv
// Handshake bundle for the shift-and-add multiplier: operand side and product side.
interface shift_add_multiplier_if #(parameter int WIDTH = 4);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p
   );
endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per clock, WIDTH steps per product,
// valid/ready handshakes on operand and product sides.
module shift_add_multiplier #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   shift_add_multiplier_if.slave bus,
   output logic                  busy
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state;
   state_t               state_nxt;
   logic [WIDTH-1:0]     m;
   logic [WIDTH-1:0]     mq;
   logic [WIDTH:0]       acc;
   logic [WIDTH:0]       sum;
   logic [CW-1:0]        cnt;
   logic [2*WIDTH-1:0]   p_r;
   logic                 last;

   assign last  = (cnt == CW'(WIDTH - 1));
   assign bus.p = p_r;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      sum = acc + (mq[0] ? {1'b0, m} : '0);
   end

   // The product is {sum, mq >> 1}: the post-shift {acc[WIDTH-1:0], mq} of the final step.
   always_ff @(posedge clk) begin
      if (rst) begin
         m   <= '0;
         mq  <= '0;
         acc <= '0;
         cnt <= '0;
         p_r <= '0;
      end else if (state == IDLE) begin
         if (bus.in_valid) begin
            m   <= bus.a;
            mq  <= bus.b;
            acc <= '0;
            cnt <= '0;
         end
      end else if (state == BUSY) begin
         {acc, mq} <= {1'b0, sum, mq[WIDTH-1:1]};
         cnt       <= cnt + 1'b1;
         if (last) p_r <= {sum, mq[WIDTH-1:1]};
      end
   end
endmodule
